// File: rtl/float_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : float_write_arbiter (with float_pkg)
// Brief    : Round-robin arbiter sharing the float register write port between
//            NumReq valid/ready requesters. Has a registered one-cycle output
//            stage and optionally drops Inf/NaN writes, counting each drop.
// Revision : 1.0 - initial release
// ============================================================================

package float_pkg;
  localparam int unsigned ExpW  = 8;
  localparam int unsigned ManW  = 23;
  localparam logic [ExpW-1:0] Bias = 8'd127;

  typedef struct packed {
    logic            sign;
    logic [ExpW-1:0] biased_exponent;
    logic [ManW-1:0] mantissa;
  } float_t;
endpackage

module float_write_arbiter #(
  parameter int NumReq         = 4,
  parameter int IdxW           = (NumReq > 1) ? $clog2(NumReq) : 1,
  parameter bit FilterSpecials = 1'b1,
  parameter int CntW           = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic              [NumReq-1:0]      req_valid_i,
  input  float_pkg::float_t [NumReq-1:0]      req_data_i,
  output logic              [NumReq-1:0]      req_ready_o,
  output logic                                wen_o,
  output float_pkg::float_t                   wdata_o,
  output logic              [IdxW-1:0]        grant_idx_o,
  output logic              [CntW-1:0]        special_cnt_o
);

  localparam logic [IdxW-1:0] c_last_idx = IdxW'(NumReq - 1);
  localparam logic [CntW-1:0] c_cnt_max  = {CntW{1'b1}};

  logic              [IdxW-1:0]   r_ptr;
  logic                           r_wen;
  float_pkg::float_t              r_wdata;
  logic              [IdxW-1:0]   r_idx;
  logic              [CntW-1:0]   r_cnt;

  logic              [NumReq-1:0] w_hi_mask;
  logic              [NumReq-1:0] w_masked;
  logic              [IdxW-1:0]   w_hi_idx;
  logic              [IdxW-1:0]   w_lo_idx;
  logic              [IdxW-1:0]   w_win;
  logic              [IdxW-1:0]   w_ptr_nxt;
  logic                           w_xfer;
  logic                           w_drop;
  float_pkg::float_t              w_sel;

  // Winner search: lowest valid index at or above ptr, else lowest valid overall (wrap).
  always_comb begin
    w_hi_mask = '0;
    w_hi_idx  = '0;
    w_lo_idx  = '0;
    for (int i = 0; i < NumReq; i++) begin
      w_hi_mask[i] = (i >= int'(r_ptr));
    end
    w_masked = req_valid_i & w_hi_mask;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (w_masked[i])    w_hi_idx = IdxW'(i);
      if (req_valid_i[i]) w_lo_idx = IdxW'(i);
    end
    w_win = (|w_masked) ? w_hi_idx : w_lo_idx;
  end

  // Grant decode, transfer detect and special-value classification of the winner.
  always_comb begin
    w_xfer      = (|req_valid_i) && !rst_i;
    req_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = w_xfer && (w_win == IdxW'(i));
    end
    w_sel     = req_data_i[w_win];
    w_drop    = FilterSpecials && (&w_sel.biased_exponent);
    w_ptr_nxt = (w_win == c_last_idx) ? '0 : w_win + IdxW'(1);
  end

  // Pointer, registered write port and saturating drop counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr   <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_wen <= w_xfer && !w_drop;
      if (w_xfer) begin
        r_ptr   <= w_ptr_nxt;
        r_wdata <= w_sel;
        r_idx   <= w_win;
        if (w_drop && (r_cnt != c_cnt_max)) begin
          r_cnt <= r_cnt + CntW'(1);
        end
      end
    end
  end

  assign wen_o         = r_wen;
  assign wdata_o       = r_wdata;
  assign grant_idx_o   = r_idx;
  assign special_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_float_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_write_arbiter
// Brief    : Scoreboard bench: the driver pushes reference-model expectations,
//            two monitors pop and compare ready (same cycle) and the write
//            port (next cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_write_arbiter;
  import float_pkg::*;

  localparam int N  = 4;
  localparam int CW = 8;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic   [N-1:0]     req_valid_i = '0;
  float_t [N-1:0]     req_data_i  = '0;
  logic   [N-1:0]     req_ready_o;
  logic               wen_o;
  float_t             wdata_o;
  logic   [1:0]       grant_idx_o;
  logic   [CW-1:0]    special_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic   wen;
    float_t wdata;
    int     idx;
    int     cnt;
  } exp_t;

  logic [N-1:0] rdy_q[$];
  exp_t         out_q[$];

  // Reference model state
  int     m_ptr = 0;
  int     m_cnt = 0;
  int     m_idx = 0;
  int     m_win = -1;
  float_t m_wdata = '0;

  float_write_arbiter #(
    .NumReq(N), .IdxW(2), .FilterSpecials(1'b1), .CntW(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .wen_o(wen_o), .wdata_o(wdata_o),
    .grant_idx_o(grant_idx_o), .special_cnt_o(special_cnt_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic float_t mk(input logic s, input logic [7:0] e, input logic [22:0] m);
    float_t f;
    f.sign = s; f.biased_exponent = e; f.mantissa = m;
    return f;
  endfunction

  function automatic float_t rnd_float();
    logic [7:0] e;
    e = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    return mk(1'($urandom_range(0, 1)), e, 23'($urandom));
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.wen = 1'b0; e.wdata = '0; e.idx = 0; e.cnt = 0;
    return e;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_idx = 0; m_wdata = '0; m_win = -1;
  endtask

  // Apply one cycle of stimulus at the falling edge and record what the spec demands.
  task automatic drive(input logic r, input logic [N-1:0] v, input float_t [N-1:0] d);
    logic [N-1:0] er;
    exp_t         eo;
    @(negedge clk_i);
    rst_i = r; req_valid_i = v; req_data_i = d;
    er = '0;
    eo = zero_exp();
    if (r) begin
      model_reset();
    end else begin
      m_win = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_win < 0 && v[j]) m_win = j;
      end
      if (m_win >= 0) begin
        er[m_win] = 1'b1;
        eo.wen    = (d[m_win].biased_exponent != 8'hFF);
        if (!eo.wen && m_cnt < 255) m_cnt++;
        m_wdata = d[m_win];
        m_idx   = m_win;
        m_ptr   = (m_win + 1) % N;
      end
      eo.wdata = m_wdata;
      eo.idx   = m_idx;
      eo.cnt   = m_cnt;
    end
    rdy_q.push_back(er);
    out_q.push_back(eo);
  endtask

  // Ready monitor: combinational grant, sampled after inputs settle.
  logic [N-1:0] mon_er;
  initial forever begin
    @(negedge clk_i); #1;
    if (rdy_q.size() > 0) begin
      mon_er = rdy_q.pop_front();
      chk("req_ready", 64'(req_ready_o), 64'(mon_er));
    end
  end

  // Write-port monitor: registered outputs, sampled just after the rising edge.
  exp_t mon_eo;
  initial forever begin
    @(posedge clk_i); #1;
    if (out_q.size() > 0) begin
      mon_eo = out_q.pop_front();
      chk("wen",         64'(wen_o),         64'(mon_eo.wen));
      chk("wdata",       64'(wdata_o),       64'(mon_eo.wdata));
      chk("grant_idx",   64'(grant_idx_o),   64'(mon_eo.idx));
      chk("special_cnt", 64'(special_cnt_o), 64'(mon_eo.cnt));
    end
  end

  float_t [N-1:0] stim;
  float_t [N-1:0] pdata;
  logic   [N-1:0] pend;

  initial begin
    stim = '0;
    // Reset, then idle.
    drive(1'b1, 4'b0000, stim);
    drive(1'b1, 4'b0000, stim);
    for (int c = 0; c < 5; c++) drive(1'b0, 4'b0000, stim);

    // All four requesting: strict rotation 0,1,2,3,...
    for (int i = 0; i < N; i++) stim[i] = mk(1'b0, 8'(Bias + 8'(i)), 23'(i * 1000 + 7));
    for (int c = 0; c < 8; c++) drive(1'b0, 4'b1111, stim);

    // Lone requester 2 for three cycles, then 1 and 3 together.
    for (int c = 0; c < 3; c++) drive(1'b0, 4'b0100, stim);
    drive(1'b0, 4'b1010, stim);
    drive(1'b0, 4'b0010, stim);
    drive(1'b0, 4'b0000, stim);

    // Requester 0: Inf/NaN then a normal value.
    stim[0] = mk(1'b0, 8'hFF, 23'h1);
    drive(1'b0, 4'b0001, stim);
    stim[0] = mk(1'b1, Bias, 23'h12345);
    drive(1'b0, 4'b0001, stim);
    drive(1'b0, 4'b0000, stim);

    // Randomized traffic; pending requests hold valid/data until granted.
    pend = '0;
    pdata = '0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          pdata[i] = rnd_float();
        end
      end
      drive(1'b0, pend, pdata);
      if (m_win >= 0) pend[m_win] = 1'b0;
    end
    drive(1'b0, 4'b0000, stim);

    // 300 back-to-back specials: counter must saturate.
    for (int c = 0; c < 300; c++) begin
      stim[0] = mk(1'($urandom_range(0, 1)), 8'hFF, 23'($urandom));
      drive(1'b0, 4'b0001, stim);
    end
    @(posedge clk_i); #2;
    chk("cnt_saturated", 64'(special_cnt_o), 64'd255);

    // Asynchronous reset in the middle of a requester-1 transfer.
    stim[1] = mk(1'b0, 8'd130, 23'h55AA);
    drive(1'b0, 4'b0010, stim);
    drive(1'b0, 4'b0010, stim);
    #2;
    rst_i = 1'b1;
    model_reset();
    out_q[out_q.size() - 1] = zero_exp();
    #1;
    chk("rst_ready", 64'(req_ready_o),   64'd0);
    chk("rst_wen",   64'(wen_o),         64'd0);
    chk("rst_wdata", 64'(wdata_o),       64'd0);
    chk("rst_idx",   64'(grant_idx_o),   64'd0);
    chk("rst_cnt",   64'(special_cnt_o), 64'd0);
    drive(1'b1, 4'b1111, stim);
    drive(1'b0, 4'b1111, stim);
    chk("first_grant_after_rst", 64'(m_win), 64'd0);
    for (int c = 0; c < 4; c++) drive(1'b0, 4'b1111, stim);
    for (int c = 0; c < 3; c++) drive(1'b0, 4'b0000, stim);

    @(posedge clk_i); #3;
    chk("scoreboard_drained", 64'(out_q.size() + rdy_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
